// File: rtl/swizzle_deserializer.sv
// Bit-serial to parallel word receiver with optional bit-order reversal.
// Define SWIZZLE_DESER_PARITY_EN to expect a trailing even-parity bit per word.
module swizzle_deserializer #(
  parameter int unsigned WIDTH   = 8,
  parameter bit          REVERSE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_perr,
  output logic [15:0]      word_count
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned WC_W  = 16;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    SHIFT  = 2'd0,
    PARITY = 2'd1,
    FULL   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] bit_idx;
  logic [WIDTH-1:0] word_d;
  logic [WC_W-1:0]  count_d;
`ifdef SWIZZLE_DESER_PARITY_EN
  logic             perr_d;
`endif

  // Destination bit of the next arriving serial bit.
  assign bit_idx = REVERSE ? (LAST_BIT - bit_cnt_q) : bit_cnt_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = out_word;
    count_d   = word_count;
`ifdef SWIZZLE_DESER_PARITY_EN
    perr_d    = out_perr;
`endif
    case (state_q)
      SHIFT: begin
        if (in_valid) begin
          word_d[bit_idx] = in_bit;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SWIZZLE_DESER_PARITY_EN
            state_d = PARITY;
`else
            state_d = FULL;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SWIZZLE_DESER_PARITY_EN
      PARITY: begin
        if (in_valid) begin
          perr_d  = (^out_word) ^ in_bit;
          state_d = FULL;
        end
      end
`endif
      FULL: begin
        if (out_ready) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          count_d   = word_count + WC_W'(1);
        end
      end
      default: begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they track it exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= SHIFT;
      bit_cnt_q  <= '0;
      out_word   <= '0;
      word_count <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      out_word   <= word_d;
      word_count <= count_d;
      in_ready   <= (state_d != FULL);
      out_valid  <= (state_d == FULL);
    end
  end

`ifdef SWIZZLE_DESER_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_perr <= 1'b0;
    end else begin
      out_perr <= perr_d;
    end
  end
`else
  assign out_perr = 1'b0;
`endif

endmodule
